snn_train_sequencer: RTL and testbench
======================================

Name: snn_train_sequencer

Overview:
- Training-phase controller for the output-layer cost stage of the fully connected stochastic network.
- Per training sample it: handshakes the sample in, pulses the cost-stage restart flag, waits out the suppression window, and opens a fixed-length error-stream window.
- During that window it enables weight updates and counts the error-stream ones.
- Reports a per-sample error count and a saturating epoch total, then sequences the next sample until the epoch is complete.

Parameters:
- N_OUT, 5, number of output neurons (width of eps and SIGN_L3).
- SUPPRESS_TIME, 8, settle cycles after the restart flag; the number of SETTLE cycles is SUPPRESS_TIME+1.
- STREAM_LEN, 256, RUN cycles per sample; legal range 1..65535.
- N_SAMPLES, 64, samples per epoch; must be at least 1.
- CW, 16, width of the per-sample error count.
- EW, 24, width of the epoch error total.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- INIT  in  1  Synchronous active-high reset.
- START  in  1  start an epoch; sampled only in IDLE.
- ABORT  in  1  terminate the epoch and return to IDLE next cycle; DONE is not asserted.
- SAMPLE_VALID  in  1  sample source presents the next Y / input vector.
- SAMPLE_READY  out  1  sequencer accepts a sample; high only in LOAD.
- eps  in  N_OUT  error bitstreams from the cost stage.
- SIGN_L3  in  N_OUT  error sign bits; counted as magnitude only, used for the sign tally.
- CLK_TRAINING_flag  out  1  one-cycle restart pulse to the cost stage and rerandomizers.
- UPDATE_EN  out  1  weight-update enable; high in RUN only.
- ERR_SUM  out  CW  per-sample count of eps ones; valid when ERR_VALID is high.
- ERR_NEG  out  CW  per-sample count of eps ones whose SIGN_L3 bit is 1.
- ERR_VALID  out  1  one-cycle strobe in REPORT.
- EPOCH_ERR  out  EW  saturating sum of ERR_SUM over the epoch; held after DONE.
- SAMPLE_IDX  out  16  index of the current sample, 0..N_SAMPLES-1.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse when the epoch completes normally.

Behaviour:
- Reset (INIT=1 at a clock edge, any state):
  - state becomes IDLE;
  - every output, ERR_SUM, ERR_NEG, EPOCH_ERR and SAMPLE_IDX become 0.
  - INIT overrides ABORT and START.
- States: IDLE, LOAD, FLAG, SETTLE, RUN, REPORT.
- IDLE:
  - START=1 moves to LOAD next cycle and clears EPOCH_ERR and SAMPLE_IDX.
  - START while BUSY is ignored.
- LOAD:
  - SAMPLE_READY=1.
  - On SAMPLE_VALID & SAMPLE_READY move to FLAG; otherwise stay in LOAD indefinitely.
- FLAG:
  - CLK_TRAINING_flag=1 for exactly this cycle.
  - Clears the per-sample counters and the settle counter.
  - Goes to SETTLE.
- SETTLE:
  - Lasts SUPPRESS_TIME+1 cycles, then goes to RUN.
  - eps is ignored and UPDATE_EN=0.
- RUN:
  - Lasts STREAM_LEN cycles. UPDATE_EN=1.
  - Each cycle, ERR_SUM += popcount(eps).
  - Each cycle, ERR_NEG += popcount(eps & SIGN_L3).
  - Both counters saturate at 2^CW-1.
  - After the last RUN cycle go to REPORT.
- REPORT:
  - ERR_VALID=1 for one cycle; ERR_SUM and ERR_NEG are stable and hold until the next FLAG.
  - EPOCH_ERR += ERR_SUM, saturating at 2^EW-1.
  - If SAMPLE_IDX == N_SAMPLES-1: pulse DONE and go to IDLE.
  - Otherwise: SAMPLE_IDX += 1 and go to LOAD.
- Timing: with the handshake in cycle t:
  - FLAG is cycle t+1;
  - RUN is cycles t+SUPPRESS_TIME+3 .. t+SUPPRESS_TIME+2+STREAM_LEN;
  - REPORT is the following cycle.
- ABORT (any non-IDLE state):
  - Go to IDLE next cycle; UPDATE_EN drops that edge.
  - No ERR_VALID, no DONE, no CLK_TRAINING_flag.
  - EPOCH_ERR and ERR_SUM hold their last values.
- ABORT in IDLE has no effect.
- ABORT together with START in IDLE: ABORT wins and the state stays IDLE.
- DONE and ERR_VALID are asserted in the same cycle for the final sample.

Test Plan:
- SUPPRESS_TIME=8, STREAM_LEN=16, N_SAMPLES=2. START, then SAMPLE_VALID held at 1, eps=5'b11111, SIGN_L3=0 → for sample 0:
  - handshake cycle t; CLK_TRAINING_flag at t+1;
  - UPDATE_EN over t+11..t+26; ERR_VALID at t+27;
  - ERR_SUM=80, ERR_NEG=0.
  - Sample 1 repeats this; DONE comes with the second ERR_VALID, and EPOCH_ERR=160.
- eps=5'b10101, SIGN_L3=5'b00100, STREAM_LEN=16 → ERR_SUM=48, ERR_NEG=16.
- eps=5'b11111 held during FLAG and SETTLE, then 0 during RUN → ERR_SUM=0.
- SAMPLE_VALID withheld for 20 cycles in LOAD → SAMPLE_READY stays 1, CLK_TRAINING_flag stays 0 and BUSY=1 throughout; the flow proceeds normally once VALID rises.
- ABORT at the 5th RUN cycle → next cycle IDLE with UPDATE_EN=0; no ERR_VALID and no DONE. A following START restarts with SAMPLE_IDX=0 and EPOCH_ERR=0.
- INIT asserted mid-RUN while START=1 and ABORT=1 → all outputs 0 and state IDLE after that edge. CW=4, eps all ones, STREAM_LEN=16 → ERR_SUM saturates at 15.

Source files
------------

// File: rtl/snn_train_sequencer.sv
// Training-phase sequencer for the output-layer cost stage.
// Per sample: load, restart flag, settle, error-stream run, report.
module snn_train_sequencer #(
  parameter int N_OUT         = 5,
  parameter int SUPPRESS_TIME = 8,
  parameter int STREAM_LEN    = 256,
  parameter int N_SAMPLES     = 64,
  parameter int CW            = 16,
  parameter int EW            = 24
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             START,
  input  logic             ABORT,
  input  logic             SAMPLE_VALID,
  output logic             SAMPLE_READY,
  input  logic [N_OUT-1:0] eps,
  input  logic [N_OUT-1:0] SIGN_L3,
  output logic             CLK_TRAINING_flag,
  output logic             UPDATE_EN,
  output logic [CW-1:0]    ERR_SUM,
  output logic [CW-1:0]    ERR_NEG,
  output logic             ERR_VALID,
  output logic [EW-1:0]    EPOCH_ERR,
  output logic [15:0]      SAMPLE_IDX,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FLAG, SETTLE, RUN, REPORT
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SUPPRESS_TIME);
  localparam logic [15:0] RUN_LAST    = 16'(STREAM_LEN - 1);
  localparam logic [15:0] IDX_LAST    = 16'(N_SAMPLES - 1);
  localparam int          SW          = CW + 8;

  state_t      state;
  logic [15:0] cnt;

  logic [7:0]    pc_all;
  logic [7:0]    pc_neg;
  logic [SW-1:0] sum_ext;
  logic [SW-1:0] neg_ext;
  logic [CW-1:0] sum_next;
  logic [CW-1:0] neg_next;
  logic [EW:0]   ep_ext;
  logic [EW-1:0] ep_next;

  function automatic logic [7:0] popcnt(input logic [N_OUT-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  // Saturating accumulate paths for sample and epoch totals
  always_comb begin
    pc_all   = popcnt(eps);
    pc_neg   = popcnt(eps & SIGN_L3);
    sum_ext  = SW'(ERR_SUM) + SW'(pc_all);
    neg_ext  = SW'(ERR_NEG) + SW'(pc_neg);
    sum_next = (|sum_ext[SW-1:CW]) ? '1 : sum_ext[CW-1:0];
    neg_next = (|neg_ext[SW-1:CW]) ? '1 : neg_ext[CW-1:0];
    ep_ext   = (EW+1)'(EPOCH_ERR) + (EW+1)'(ERR_SUM);
    ep_next  = ep_ext[EW] ? '1 : ep_ext[EW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state             <= IDLE;
      cnt               <= '0;
      SAMPLE_READY      <= 1'b0;
      CLK_TRAINING_flag <= 1'b0;
      UPDATE_EN         <= 1'b0;
      ERR_SUM           <= '0;
      ERR_NEG           <= '0;
      ERR_VALID         <= 1'b0;
      EPOCH_ERR         <= '0;
      SAMPLE_IDX        <= '0;
      BUSY              <= 1'b0;
      DONE              <= 1'b0;
    end else if (ABORT && state != IDLE) begin
      state             <= IDLE;
      SAMPLE_READY      <= 1'b0;
      CLK_TRAINING_flag <= 1'b0;
      UPDATE_EN         <= 1'b0;
      ERR_VALID         <= 1'b0;
      BUSY              <= 1'b0;
      DONE              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START && !ABORT) begin
            state        <= LOAD;
            SAMPLE_READY <= 1'b1;
            BUSY         <= 1'b1;
            EPOCH_ERR    <= '0;
            SAMPLE_IDX   <= '0;
          end
        end
        LOAD: begin
          if (SAMPLE_VALID) begin
            state             <= FLAG;
            SAMPLE_READY      <= 1'b0;
            CLK_TRAINING_flag <= 1'b1;
          end
        end
        FLAG: begin
          state             <= SETTLE;
          CLK_TRAINING_flag <= 1'b0;
          ERR_SUM           <= '0;
          ERR_NEG           <= '0;
          cnt               <= '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            UPDATE_EN <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          ERR_SUM <= sum_next;
          ERR_NEG <= neg_next;
          if (cnt == RUN_LAST) begin
            state     <= REPORT;
            UPDATE_EN <= 1'b0;
            ERR_VALID <= 1'b1;
            DONE      <= (SAMPLE_IDX == IDX_LAST);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        REPORT: begin
          ERR_VALID <= 1'b0;
          DONE      <= 1'b0;
          EPOCH_ERR <= ep_next;
          if (SAMPLE_IDX == IDX_LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            state        <= LOAD;
            SAMPLE_READY <= 1'b1;
            SAMPLE_IDX   <= SAMPLE_IDX + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_train_sequencer.sv
// Scoreboard bench for snn_train_sequencer: directed samples,
// report monitor pops expected per-sample results.
module tb_snn_train_sequencer;

  logic        clk = 1'b0;
  logic        init, start, abort, s_valid;
  logic [4:0]  eps, sign;
  logic        s_ready, flag, upd, err_valid, busy, done;
  logic [15:0] err_sum, err_neg, s_idx;
  logic [23:0] epoch_err;

  logic        start4, valid4;
  logic [4:0]  eps4, sign4;
  logic        ready4, flag4, upd4, err_valid4, busy4, done4;
  logic [3:0]  err_sum4, err_neg4;
  logic [15:0] s_idx4;
  logic [23:0] epoch_err4;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] sum;
    logic [15:0] neg;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t mx;

  always #5 clk = ~clk;

  snn_train_sequencer #(
    .N_OUT(5), .SUPPRESS_TIME(8), .STREAM_LEN(16),
    .N_SAMPLES(2), .CW(16), .EW(24)
  ) dut (
    .CLK(clk), .INIT(init), .START(start), .ABORT(abort),
    .SAMPLE_VALID(s_valid), .SAMPLE_READY(s_ready),
    .eps(eps), .SIGN_L3(sign),
    .CLK_TRAINING_flag(flag), .UPDATE_EN(upd),
    .ERR_SUM(err_sum), .ERR_NEG(err_neg), .ERR_VALID(err_valid),
    .EPOCH_ERR(epoch_err), .SAMPLE_IDX(s_idx),
    .BUSY(busy), .DONE(done)
  );

  snn_train_sequencer #(
    .N_OUT(5), .SUPPRESS_TIME(8), .STREAM_LEN(16),
    .N_SAMPLES(1), .CW(4), .EW(24)
  ) dut4 (
    .CLK(clk), .INIT(init), .START(start4), .ABORT(1'b0),
    .SAMPLE_VALID(valid4), .SAMPLE_READY(ready4),
    .eps(eps4), .SIGN_L3(sign4),
    .CLK_TRAINING_flag(flag4), .UPDATE_EN(upd4),
    .ERR_SUM(err_sum4), .ERR_NEG(err_neg4), .ERR_VALID(err_valid4),
    .EPOCH_ERR(epoch_err4), .SAMPLE_IDX(s_idx4),
    .BUSY(busy4), .DONE(done4)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_flag"}, 32'(flag), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
    chk({tag, "_sum"}, 32'(err_sum), 32'd0);
    chk({tag, "_neg"}, 32'(err_neg), 32'd0);
    chk({tag, "_valid"}, 32'(err_valid), 32'd0);
    chk({tag, "_epoch"}, 32'(epoch_err), 32'd0);
    chk({tag, "_idx"}, 32'(s_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Returns in the handshake cycle (VALID and READY both high)
  task automatic wait_ready();
    int n;
    n = 0;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (!s_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL handshake_timeout: got READY=0 expected READY=1");
    end
  endtask

  task automatic full_sample(input logic [4:0] e_set,
                             input logic [4:0] e_run,
                             input logic [4:0] sg,
                             input int xs, input int xn,
                             input logic xd, input int idx);
    exp_t x;
    wait_ready();
    x.sum = 16'(xs);
    x.neg = 16'(xn);
    x.done = xd;
    q.push_back(x);
    chk("sample_idx", 32'(s_idx), 32'(idx));
    eps = e_set;
    sign = sg;
    step();
    chk("flag_t1", 32'(flag), 32'd1);
    chk("ready_t1", 32'(s_ready), 32'd0);
    repeat (9) step();
    chk("settle_upd", 32'(upd), 32'd0);
    chk("settle_flag", 32'(flag), 32'd0);
    step();
    eps = e_run;
    chk("run_first_upd", 32'(upd), 32'd1);
    repeat (15) step();
    chk("run_last_upd", 32'(upd), 32'd1);
    step();
    chk("report_valid", 32'(err_valid), 32'd1);
    chk("report_upd", 32'(upd), 32'd0);
    eps = '0;
  endtask

  always @(negedge clk) begin
    if (!init) begin
      if (err_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_err_valid: got 1 expected 0");
        end else begin
          mx = q.pop_front();
          chk("err_sum", 32'(err_sum), 32'(mx.sum));
          chk("err_neg", 32'(err_neg), 32'(mx.neg));
          chk("done_with_valid", 32'(done), 32'(mx.done));
        end
      end else if (done) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok_r, ok_f, ok_b;
    int n;
    init = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    eps = '0; sign = '0;
    start4 = 1'b0; valid4 = 1'b0; eps4 = '0; sign4 = '0;
    step();
    step();
    chk_zero("reset");
    chk("reset4_busy", 32'(busy4), 32'd0);
    init = 1'b0;
    step();

    // ABORT wins over START in IDLE
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_ready", 32'(s_ready), 32'd0);

    // Epoch 1: all-ones error streams, two samples
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ep1_busy", 32'(busy), 32'd1);
    full_sample(5'b11111, 5'b11111, 5'b00000, 80, 0, 1'b0, 0);
    full_sample(5'b11111, 5'b11111, 5'b00000, 80, 0, 1'b1, 1);
    step();
    chk("ep1_epoch_err", 32'(epoch_err), 32'd160);
    chk("ep1_idle", 32'(busy), 32'd0);
    chk("ep1_idx_hold", 32'(s_idx), 32'd1);

    // Epoch 2: mixed signs, withheld VALID, settle-only ones
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ep2_epoch_clr", 32'(epoch_err), 32'd0);
    full_sample(5'b00000, 5'b10101, 5'b00100, 48, 16, 1'b0, 0);
    s_valid = 1'b0;
    ok_r = 1; ok_f = 1; ok_b = 1;
    repeat (20) begin
      step();
      if (s_ready !== 1'b1) ok_r = 0;
      if (flag !== 1'b0) ok_f = 0;
      if (busy !== 1'b1) ok_b = 0;
    end
    chk("withhold_ready", 32'(ok_r), 32'd1);
    chk("withhold_flag", 32'(ok_f), 32'd1);
    chk("withhold_busy", 32'(ok_b), 32'd1);
    full_sample(5'b11111, 5'b00000, 5'b00000, 0, 0, 1'b1, 1);
    step();
    chk("ep2_epoch_err", 32'(epoch_err), 32'd48);

    // Epoch 3: ABORT on the 5th RUN cycle
    start = 1'b1;
    step();
    start = 1'b0;
    wait_ready();
    eps = 5'b11111;
    repeat (15) step();
    chk("abort_pre_upd", 32'(upd), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_upd", 32'(upd), 32'd0);
    chk("abort_flag", 32'(flag), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd0);
    repeat (20) step();
    chk("abort_stay_idle", 32'(busy), 32'd0);
    chk("abort_epoch_hold", 32'(epoch_err), 32'd0);

    // Epoch 4: restart, then INIT mid-RUN with START and ABORT high
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_idx", 32'(s_idx), 32'd0);
    chk("restart_epoch", 32'(epoch_err), 32'd0);
    full_sample(5'b11111, 5'b11111, 5'b00000, 80, 0, 1'b0, 0);
    wait_ready();
    eps = 5'b11111;
    repeat (14) step();
    chk("init_pre_upd", 32'(upd), 32'd1);
    init = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    chk_zero("init_mid_run");
    init = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    eps = '0;
    step();
    chk("post_init_idle", 32'(busy), 32'd0);

    // CW=4 instance: counters saturate at 15
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    valid4 = 1'b1;
    eps4 = 5'b11111;
    sign4 = 5'b11111;
    n = 0;
    while (!err_valid4 && n < 60) begin
      step();
      n++;
    end
    chk("sat4_valid", 32'(err_valid4), 32'd1);
    chk("sat4_sum", 32'(err_sum4), 32'd15);
    chk("sat4_neg", 32'(err_neg4), 32'd15);
    chk("sat4_done", 32'(done4), 32'd1);
    valid4 = 1'b0;
    step();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
